// File: rtl/ddr_burst_arbiter.sv
// Burst scheduler between the SD-side write FIFO and the VGA-side read FIFO.
// Issues one fixed-length DDR command per grant, steers data strobes and tracks frame addresses.
module ddr_burst_arbiter #(
  parameter int ADDR_W      = 24,
  parameter int BURST_LEN   = 64,
  parameter int FRAME_WORDS = 393216,
  parameter int FIFO_AW     = 10,
  parameter int RD_LOW      = 256,
  parameter int RD_READY    = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ddr_init_done,
  input  logic              wr_load,
  input  logic              rd_load,
  input  logic [FIFO_AW:0]  wrfifo_usedw,
  input  logic [FIFO_AW:0]  rdfifo_usedw,
  input  logic              cmd_ready,
  output logic              cmd_valid,
  output logic              cmd_write,
  output logic [ADDR_W-1:0] cmd_addr,
  input  logic              wdata_req,
  output logic              wrfifo_rdreq,
  input  logic              rdata_valid,
  output logic              rdfifo_wrreq,
  output logic              frame_write_done,
  output logic              frame_read_done,
  output logic              data_valid
);

  localparam int UW = FIFO_AW + 1;
  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  localparam logic [UW-1:0]     BURST_U    = UW'(BURST_LEN);
  localparam logic [UW-1:0]     RD_SPACE_U = UW'((1 << FIFO_AW) - BURST_LEN);
  localparam logic [UW-1:0]     RD_LOW_U   = UW'(RD_LOW);
  localparam logic [UW-1:0]     RD_READY_U = UW'(RD_READY);
  localparam logic [ADDR_W-1:0] BURST_A    = ADDR_W'(BURST_LEN);
  localparam logic [ADDR_W-1:0] FRAME_A    = ADDR_W'(FRAME_WORDS);
  localparam logic [BW-1:0]     BEAT_LAST  = BW'(BURST_LEN - 1);

  typedef enum logic [2:0] {IDLE, WR_CMD, WR_DATA, RD_CMD, RD_DATA} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [ADDR_W-1:0] wr_addr_inc, rd_addr_inc;
  logic [BW-1:0]     beat_cnt;
  logic              last_grant;
  logic              wr_load_pend, rd_load_pend;
  logic              wr_elig, rd_elig, rd_urgent;
  logic              wr_busy, rd_busy, wr_last, rd_last;
  logic              wr_clear, rd_clear;

  assign wr_elig   = ddr_init_done && !frame_write_done && (wrfifo_usedw >= BURST_U);
  // Free space >= BURST_LEN, rewritten as a fill-level bound to avoid underflow
  assign rd_elig   = ddr_init_done && frame_write_done && (rdfifo_usedw <= RD_SPACE_U);
  assign rd_urgent = rd_elig && (rdfifo_usedw < RD_LOW_U);

  assign wrfifo_rdreq = (state == WR_DATA) && wdata_req;
  assign rdfifo_wrreq = (state == RD_DATA) && rdata_valid;

  assign wr_busy = (state == WR_CMD) || (state == WR_DATA);
  assign rd_busy = (state == RD_CMD) || (state == RD_DATA);
  assign wr_last = wrfifo_rdreq && (beat_cnt == BEAT_LAST);
  assign rd_last = rdfifo_wrreq && (beat_cnt == BEAT_LAST);

  // A load seen during a same-direction burst is deferred to its final word
  assign wr_clear = wr_last ? (wr_load_pend || wr_load) : (!wr_busy && wr_load);
  assign rd_clear = rd_last ? (rd_load_pend || rd_load) : (!rd_busy && rd_load);

  assign wr_addr_inc = wr_addr + BURST_A;
  assign rd_addr_inc = rd_addr + BURST_A;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (rd_urgent)              state_next = RD_CMD;
        else if (wr_elig && rd_elig) state_next = last_grant ? RD_CMD : WR_CMD;
        else if (wr_elig)           state_next = WR_CMD;
        else if (rd_elig)           state_next = RD_CMD;
      end
      WR_CMD:  if (cmd_ready) state_next = WR_DATA;
      WR_DATA: if (wr_last)   state_next = IDLE;
      RD_CMD:  if (cmd_ready) state_next = RD_DATA;
      RD_DATA: if (rd_last)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_valid        <= 1'b0;
      cmd_write        <= 1'b0;
      cmd_addr         <= '0;
      last_grant       <= 1'b0;
      beat_cnt         <= '0;
      wr_addr          <= '0;
      rd_addr          <= '0;
      wr_load_pend     <= 1'b0;
      rd_load_pend     <= 1'b0;
      frame_write_done <= 1'b0;
      frame_read_done  <= 1'b0;
      data_valid       <= 1'b0;
    end else begin
      cmd_valid       <= (state_next == WR_CMD) || (state_next == RD_CMD);
      frame_read_done <= 1'b0;

      if (state == IDLE && state_next == WR_CMD) begin
        cmd_write  <= 1'b1;
        cmd_addr   <= wr_clear ? '0 : wr_addr;
        last_grant <= 1'b1;
      end else if (state == IDLE && state_next == RD_CMD) begin
        cmd_write  <= 1'b0;
        cmd_addr   <= rd_clear ? '0 : rd_addr;
        last_grant <= 1'b0;
      end

      if (state == WR_CMD || state == RD_CMD)   beat_cnt <= '0;
      else if (wrfifo_rdreq || rdfifo_wrreq)    beat_cnt <= beat_cnt + BW'(1);

      if (wr_last)                 wr_load_pend <= 1'b0;
      else if (wr_busy && wr_load) wr_load_pend <= 1'b1;
      if (rd_last)                 rd_load_pend <= 1'b0;
      else if (rd_busy && rd_load) rd_load_pend <= 1'b1;

      if (wr_clear) begin
        wr_addr          <= '0;
        frame_write_done <= 1'b0;
      end else if (wr_last) begin
        wr_addr <= wr_addr_inc;
        if (wr_addr_inc == FRAME_A) frame_write_done <= 1'b1;
      end

      if (rd_clear) begin
        rd_addr    <= '0;
        data_valid <= 1'b0;
      end else begin
        if (rd_last) begin
          if (rd_addr_inc == FRAME_A) begin
            rd_addr         <= '0;
            frame_read_done <= 1'b1;
          end else begin
            rd_addr <= rd_addr_inc;
          end
        end
        if (rdfifo_usedw >= RD_READY_U) data_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ddr_burst_arbiter.sv
// Directed bench for ddr_burst_arbiter; the frame is shortened to four bursts to keep runs short.
module tb_ddr_burst_arbiter;

  localparam int ADDR_W = 24;
  localparam int FAW    = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              ddr_init_done, wr_load, rd_load;
  logic [FAW:0]      wrfifo_usedw, rdfifo_usedw;
  logic              cmd_ready, cmd_valid, cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic              wdata_req, wrfifo_rdreq, rdata_valid, rdfifo_wrreq;
  logic              frame_write_done, frame_read_done, data_valid;

  int vectors = 0;
  int miscompares = 0;

  ddr_burst_arbiter #(
    .ADDR_W(ADDR_W), .BURST_LEN(64), .FRAME_WORDS(256),
    .FIFO_AW(FAW), .RD_LOW(256), .RD_READY(512)
  ) dut (
    .clk(clk), .rst(rst), .ddr_init_done(ddr_init_done),
    .wr_load(wr_load), .rd_load(rd_load),
    .wrfifo_usedw(wrfifo_usedw), .rdfifo_usedw(rdfifo_usedw),
    .cmd_ready(cmd_ready), .cmd_valid(cmd_valid), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .wdata_req(wdata_req), .wrfifo_rdreq(wrfifo_rdreq),
    .rdata_valid(rdata_valid), .rdfifo_wrreq(rdfifo_wrreq),
    .frame_write_done(frame_write_done), .frame_read_done(frame_read_done),
    .data_valid(data_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish, vectors=%0d", vectors);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_valid"}, 32'(cmd_valid), 0);
    chk({tag, "_cmd_write"}, 32'(cmd_write), 0);
    chk({tag, "_cmd_addr"}, 32'(cmd_addr), 0);
    chk({tag, "_wrfifo_rdreq"}, 32'(wrfifo_rdreq), 0);
    chk({tag, "_rdfifo_wrreq"}, 32'(rdfifo_wrreq), 0);
    chk({tag, "_frame_write_done"}, 32'(frame_write_done), 0);
    chk({tag, "_frame_read_done"}, 32'(frame_read_done), 0);
    chk({tag, "_data_valid"}, 32'(data_valid), 0);
  endtask

  task automatic wait_grant(input string tag);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (cmd_valid) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    chk({tag, "_grant_seen"}, 32'(got), 1);
  endtask

  // Returns in the first IDLE cycle after the burst's last word
  task automatic wr_burst(input logic [ADDR_W-1:0] exp_addr);
    int n;
    wait_grant("wr");
    chk("wr_cmd_write", 32'(cmd_write), 1);
    chk("wr_cmd_addr", 32'(cmd_addr), 32'(exp_addr));
    tick();
    chk("wr_cmd_one_cycle", 32'(cmd_valid), 0);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (wrfifo_rdreq) n++;
      else if (n > 0) break;
      tick();
    end
    chk("wr_words", 32'(n), 64);
  endtask

  task automatic rd_burst(input logic [ADDR_W-1:0] exp_addr, input int load_at, output logic frd);
    int n;
    wait_grant("rd");
    chk("rd_cmd_write", 32'(cmd_write), 0);
    chk("rd_cmd_addr", 32'(cmd_addr), 32'(exp_addr));
    tick();
    chk("rd_cmd_one_cycle", 32'(cmd_valid), 0);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      rd_load = 1'b0;
      if (rdfifo_wrreq) begin
        n++;
        if (n == load_at) rd_load = 1'b1;
      end else if (n > 0) begin
        break;
      end
      tick();
    end
    rd_load = 1'b0;
    frd = frame_read_done;
    chk("rd_words", 32'(n), 64);
  endtask

  initial begin
    logic frd;
    rst = 1'b1;
    ddr_init_done = 1'b0;
    wr_load = 1'b0;
    rd_load = 1'b0;
    wrfifo_usedw = '0;
    rdfifo_usedw = '0;
    cmd_ready = 1'b0;
    wdata_req = 1'b0;
    rdata_valid = 1'b0;
    tick();
    tick();
    chk_reset_outputs("rst0");

    // Write-only fill
    ddr_init_done = 1'b1;
    wrfifo_usedw = 11'd64;
    cmd_ready = 1'b1;
    wdata_req = 1'b1;
    tick();
    rst = 1'b0;
    wr_burst(24'd0);
    chk("fwd_after_first", 32'(frame_write_done), 0);
    wr_burst(24'd64);
    wr_burst(24'd128);
    wr_burst(24'd192);
    rdfifo_usedw = 11'd1000;
    chk("frame_write_done", 32'(frame_write_done), 1);

    // Frame done: no write grant even with a full write FIFO
    wrfifo_usedw = 11'd1024;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("no_grant_after_frame", 32'(cmd_valid), 0);
    end
    chk("data_valid_set", 32'(data_valid), 1);

    // Read priority and wrap
    rdfifo_usedw = 11'd100;
    wrfifo_usedw = 11'd512;
    rdata_valid = 1'b1;
    rd_burst(24'd0, 0, frd);
    chk("frd_burst0", 32'(frd), 0);
    rd_burst(24'd64, 0, frd);
    rd_burst(24'd128, 0, frd);
    rd_burst(24'd192, 0, frd);
    chk("frd_wrap_pulse", 32'(frd), 1);
    tick();
    chk("frd_one_cycle", 32'(frame_read_done), 0);
    chk("rd_after_wrap_valid", 32'(cmd_valid), 1);
    chk("rd_after_wrap_addr", 32'(cmd_addr), 0);
    rd_burst(24'd0, 0, frd);
    chk("frd_after_wrap", 32'(frd), 0);
    rd_burst(24'd64, 0, frd);
    chk("data_valid_sticky", 32'(data_valid), 1);

    // rd_load on the 10th word of the burst at 128
    rd_burst(24'd128, 10, frd);
    chk("frd_load_burst", 32'(frd), 0);
    chk("data_valid_cleared", 32'(data_valid), 0);
    rd_burst(24'd0, 0, frd);
    chk("data_valid_below_ready", 32'(data_valid), 0);
    rdfifo_usedw = 11'd512;
    rd_burst(24'd64, 0, frd);
    chk("data_valid_at_ready", 32'(data_valid), 1);

    // wr_load in IDLE restarts the frame write
    rdfifo_usedw = 11'd1000;
    wrfifo_usedw = 11'd0;
    wr_load = 1'b1;
    tick();
    wr_load = 1'b0;
    chk("wr_load_clears_fwd", 32'(frame_write_done), 0);
    chk("wr_load_no_grant", 32'(cmd_valid), 0);
    wrfifo_usedw = 11'd64;
    rdfifo_usedw = 11'd600;
    wr_burst(24'd0);

    // Backpressure then reset mid-WR_DATA
    cmd_ready = 1'b0;
    wait_grant("stall");
    for (int i = 0; i < 20; i++) begin
      chk("stall_valid", 32'(cmd_valid), 1);
      chk("stall_addr", 32'(cmd_addr), 64);
      chk("stall_write", 32'(cmd_write), 1);
      tick();
    end
    cmd_ready = 1'b1;
    tick();
    chk("post_stall_rdreq", 32'(wrfifo_rdreq), 1);
    for (int i = 0; i < 5; i++) tick();
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("rst_mid");
    ddr_init_done = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("init_low_no_grant", 32'(cmd_valid), 0);
    chk("init_low_no_rdreq", 32'(wrfifo_rdreq), 0);
    chk("init_low_no_wrreq", 32'(rdfifo_wrreq), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ddr_burst_arbiter.md
# ddr_burst_arbiter

Schedules DDR burst traffic between the SD-side write FIFO and the VGA-side read FIFO inside the DDR two-FIFO subsystem. It decides which FIFO is served next and issues one fixed-length burst command per grant to the DDR controller local interface. It also steers the controller's per-word data strobes to the granted FIFO and maintains the frame write/read address counters. It generates the frame-done and display-ready status used by the top level.

## Interface
- ADDR_W, 24, DDR word-address width
- BURST_LEN, 64, words per burst (power of two)
- FRAME_WORDS, 393216, 32-bit words per frame (1024x768x16 bit); multiple of BURST_LEN
- FIFO_AW, 10, FIFO address width; depth = 2^FIFO_AW
- RD_LOW, 256, read-FIFO level below which a read has priority
- RD_READY, 512, read-FIFO level that raises data_valid

- clk  in  1  DDR local-interface clock
- rst  in  1  asynchronous reset, active-high
- ddr_init_done  in  1  controller calibrated; no grants while low
- wr_load  in  1  pulse: restart frame write at address 0
- rd_load  in  1  pulse: restart frame read at address 0
- wrfifo_usedw  in  FIFO_AW+1  write-FIFO fill level
- rdfifo_usedw  in  FIFO_AW+1  read-FIFO fill level
- cmd_ready  in  1  controller accepts command
- cmd_valid  out  1  burst command valid
- cmd_write  out  1  1 = write burst, 0 = read burst
- cmd_addr  out  ADDR_W  burst start word address
- wdata_req  in  1  controller consumes one write word this cycle
- wrfifo_rdreq  out  1  pop write FIFO
- rdata_valid  in  1  controller returns one read word this cycle
- rdfifo_wrreq  out  1  push read FIFO
- frame_write_done  out  1  whole frame stored
- frame_read_done  out  1  one-cycle pulse at read-address wrap
- data_valid  out  1  read FIFO primed after rd_load

## Operation
- FSM states: IDLE, WR_CMD, WR_DATA, RD_CMD, RD_DATA.
- Write eligible: ddr_init_done & !frame_write_done & wrfifo_usedw >= BURST_LEN.
- Read eligible: ddr_init_done & frame_write_done & (2^FIFO_AW - rdfifo_usedw) >= BURST_LEN.
- IDLE arbitration:
  - Read wins if rdfifo_usedw < RD_LOW.
  - Otherwise, if both are eligible, grant the one not served last (last_grant register, reset = read).
  - Otherwise grant the single eligible requester; stay in IDLE if none is eligible.
- WR_CMD/RD_CMD: cmd_valid=1, cmd_write=1 or 0, cmd_addr = wr_addr/rd_addr. The FSM moves to the data state on the edge where cmd_ready=1.
- WR_DATA:
  - wrfifo_rdreq = wdata_req (combinational, gated by state).
  - Count words; on the BURST_LEN-th word, go to IDLE and set wr_addr += BURST_LEN.
  - When wr_addr reaches FRAME_WORDS, set frame_write_done=1 and hold wr_addr.
- RD_DATA:
  - rdfifo_wrreq = rdata_valid (gated by state).
  - On the BURST_LEN-th word, go to IDLE and advance rd_addr.
  - At FRAME_WORDS, rd_addr wraps to 0 and frame_read_done pulses.
- data_valid: cleared by rd_load; set when rdfifo_usedw >= RD_READY; then sticky until the next rd_load.
- wr_load/rd_load in IDLE: applied on the next edge.
  - wr_load clears wr_addr and frame_write_done.
  - rd_load clears rd_addr and data_valid.
- wr_load/rd_load during a CMD or DATA state of the same direction: latched as pending. The burst completes at the old address, and the reset is applied on the final-word edge, replacing the increment.
- wdata_req/rdata_valid outside the matching data state: ignored; no FIFO strobe.

## Timing
- Reset values: cmd_valid=0, cmd_write=0, cmd_addr=0, wrfifo_rdreq=0, rdfifo_wrreq=0, frame_write_done=0, frame_read_done=0, data_valid=0. Internal reset values: state=IDLE, wr_addr=0, rd_addr=0.
- Arbitration is 1 cycle: eligibility is sampled in IDLE, and cmd_valid rises on the next edge. Minimum one IDLE cycle between bursts.
- cmd_valid, cmd_write and cmd_addr are registered and stable until accepted.
- FIFO strobes have zero latency from wdata_req/rdata_valid.
- frame_read_done is high exactly one cycle, coincident with the IDLE entry after the wrapping burst.
- ddr_init_done falling mid-burst: the current burst completes and no new grant is issued.

## Test plan
- Write-only fill: frame_write_done=0, wrfifo_usedw=64, cmd_ready tied 1, wdata_req every cycle.
  - Expected: cmd_valid for 1 cycle with cmd_write=1, cmd_addr=0.
  - Expected: 64 wrfifo_rdreq pulses; next burst at address 64.
- Frame completion: run 6144 write bursts.
  - Expected: frame_write_done=1 after the last one; no further write grants even with wrfifo_usedw=1024.
- Read wrap and priority: frame_write_done=1, rdfifo_usedw=100, wrfifo_usedw=512.
  - Expected: read always granted.
  - Expected: after 6144 read bursts, frame_read_done pulses one cycle and cmd_addr returns to 0.
- Round-robin: rdfifo_usedw=600, both requesters eligible, frame_write_done held at 1 for read eligibility.
  - Expected: read is blocked by the frame_write_done gate, so no alternation occurs. Drive wr_load then refill to confirm writes resume at address 0.
- rd_load mid-burst: assert rd_load on the 10th word of a read burst at address 128.
  - Expected: the burst finishes 64 words; the next read address is 0; data_valid is 0 until rdfifo_usedw reaches 512.
- Backpressure/reset: cmd_ready held 0 for 20 cycles, then rst asserted mid-WR_DATA.
  - Expected: cmd_valid/cmd_addr stable throughout the stall.
  - Expected: after reset, all outputs are at reset values and the FSM is in IDLE.
